vx_onehot_mask_builder: RTL and testbench

Sequential index-to-onehot decoder, the inverse of the onehot-to-index encoder used in arbiters and thread-mask logic. Consumes a stream of binary indices over a valid/ready handshake, decodes each to a onehot bit, ORs the bits into a per-group mask, and emits the completed mask with a population count when the group's last beat arrives. Sits where schedulers rebuild thread/lane masks from serialized index streams.

---
 rtl/vx_onehot_mask_builder_if.sv | 29 ++
 rtl/vx_onehot_mask_builder.sv | 90 +++++++++
 tb/tb_vx_onehot_mask_builder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_onehot_mask_builder_if.sv
// Stream bundle for the onehot mask builder: an index input stream and a
// completed-mask output stream, each with its own valid/ready handshake.
interface vx_onehot_mask_builder_if #(
   parameter int N = 8
);
   localparam int LN = (N > 1) ? $clog2(N) : 1;

   logic          in_valid;
   logic [LN-1:0] in_index;
   logic          in_last;
   logic          in_ready;
   logic          out_valid;
   logic [N-1:0]  out_mask;
   logic [LN:0]   out_count;
   logic          out_error;
   logic          out_ready;

   // Producer of indices / consumer of masks
   modport master (
      output in_valid, in_index, in_last, out_ready,
      input  in_ready, out_valid, out_mask, out_count, out_error
   );

   // The mask builder itself
   modport slave (
      input  in_valid, in_index, in_last, out_ready,
      output in_ready, out_valid, out_mask, out_count, out_error
   );
endinterface

// File: rtl/vx_onehot_mask_builder.sv
// Sequential index-to-onehot decoder. Each accepted index sets one bit of a
// per-group accumulator; the beat flagged last publishes the accumulated mask
// with its population count and an out-of-range error flag.
module vx_onehot_mask_builder #(
   parameter int N       = 8,
   parameter bit REVERSE = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   vx_onehot_mask_builder_if.slave  bus
);
   localparam int LN = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t        state_reg;
   logic [N-1:0]  acc_mask_reg;
   logic [LN:0]   acc_count_reg;
   logic          acc_err_reg;
   logic [N-1:0]  out_mask_reg;
   logic [LN:0]   out_count_reg;
   logic          out_error_reg;

   logic [N-1:0]  onehot;
   logic          in_range;
   logic          new_bit;
   logic          in_fire;
   logic          last_fire;
   logic [N-1:0]  mask_next;
   logic [LN:0]   count_next;
   logic          err_next;

   // Each mask bit owns exactly one index value; an index >= N matches no bit,
   // so out-of-range beats decode to an all-zero onehot.
   for (genvar gi = 0; gi < N; gi++) begin : g_decode
      localparam int MAP = REVERSE ? (N - 1 - gi) : gi;
      assign onehot[gi] = (bus.in_index == LN'(MAP));
   end

   assign in_range   = ({1'b0, bus.in_index} < (LN + 1)'(N));
   // Count only bits that were not already set, keeping count == popcount(mask)
   assign new_bit    = |(onehot & ~acc_mask_reg);
   assign mask_next  = acc_mask_reg | onehot;
   assign count_next = acc_count_reg + {{LN{1'b0}}, new_bit};
   assign err_next   = acc_err_reg | ~in_range;

   // Ready depends only on the registered output state and the consumer
   assign bus.in_ready = (state_reg == EMPTY) || bus.out_ready;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign last_fire    = in_fire && bus.in_last;

   assign bus.out_valid = (state_reg == FULL);
   assign bus.out_mask  = out_mask_reg;
   assign bus.out_count = out_count_reg;
   assign bus.out_error = out_error_reg;

   // Accumulate beats, publish on the last beat, retire on the output handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= EMPTY;
         acc_mask_reg  <= '0;
         acc_count_reg <= '0;
         acc_err_reg   <= 1'b0;
         out_mask_reg  <= '0;
         out_count_reg <= '0;
         out_error_reg <= 1'b0;
      end else if (last_fire) begin
         // Accepting a last beat implies the old output (if any) is consumed
         state_reg     <= FULL;
         out_mask_reg  <= mask_next;
         out_count_reg <= count_next;
         out_error_reg <= err_next;
         acc_mask_reg  <= '0;
         acc_count_reg <= '0;
         acc_err_reg   <= 1'b0;
      end else begin
         if (in_fire) begin
            acc_mask_reg  <= mask_next;
            acc_count_reg <= count_next;
            acc_err_reg   <= err_next;
         end
         if ((state_reg == FULL) && bus.out_ready) begin
            state_reg <= EMPTY;
         end
      end
   end
endmodule

// File: tb/tb_vx_onehot_mask_builder.sv
// Bench for the onehot mask builder: three instances (N=8 forward, N=8
// reversed, N=6 forward) share clock and reset; directed scenarios plus
// randomized groups checked against a set-based reference model.
module tb_vx_onehot_mask_builder;
   logic clk;
   logic reset;

   logic [2:0]      iv;
   logic [2:0]      il;
   logic [2:0]      ordy;
   logic [2:0][2:0] ii;
   logic [2:0]      irdy;
   logic [2:0]      ov;
   logic [2:0]      oe;
   logic [2:0][7:0] om;
   logic [2:0][3:0] oc;

   int checks = 0;
   int passes = 0;

   vx_onehot_mask_builder_if #(.N(8)) if0 ();
   vx_onehot_mask_builder_if #(.N(8)) if1 ();
   vx_onehot_mask_builder_if #(.N(6)) if2 ();

   vx_onehot_mask_builder #(.N(8), .REVERSE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   vx_onehot_mask_builder #(.N(8), .REVERSE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
   vx_onehot_mask_builder #(.N(6), .REVERSE(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

   assign if0.in_valid = iv[0];
   assign if0.in_index = ii[0];
   assign if0.in_last  = il[0];
   assign if0.out_ready = ordy[0];
   assign if1.in_valid = iv[1];
   assign if1.in_index = ii[1];
   assign if1.in_last  = il[1];
   assign if1.out_ready = ordy[1];
   assign if2.in_valid = iv[2];
   assign if2.in_index = ii[2];
   assign if2.in_last  = il[2];
   assign if2.out_ready = ordy[2];

   assign irdy[0] = if0.in_ready;
   assign irdy[1] = if1.in_ready;
   assign irdy[2] = if2.in_ready;
   assign ov[0]   = if0.out_valid;
   assign ov[1]   = if1.out_valid;
   assign ov[2]   = if2.out_valid;
   assign oe[0]   = if0.out_error;
   assign oe[1]   = if1.out_error;
   assign oe[2]   = if2.out_error;
   assign om[0]   = if0.out_mask;
   assign om[1]   = if1.out_mask;
   assign om[2]   = {2'b00, if2.out_mask};
   assign oc[0]   = if0.out_count;
   assign oc[1]   = if1.out_count;
   assign oc[2]   = if2.out_count;

   always #5 clk = ~clk;

   // Reference: a group's mask is the set of mapped in-range indices
   function automatic void ref_group(input int n, input bit rv, input int q[$],
                                     output logic [7:0] m, output logic [3:0] c,
                                     output logic e);
      m = '0;
      e = 1'b0;
      foreach (q[k]) begin
         if (q[k] >= n) e = 1'b1;
         else if (rv) m[n - 1 - q[k]] = 1'b1;
         else m[q[k]] = 1'b1;
      end
      c = 4'($countones(m));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded)
   task automatic send(input int d, input int idx, input bit last);
      int t = 0;
      iv[d] = 1'b1;
      ii[d] = idx[2:0];
      il[d] = last;
      while (!irdy[d] && t < 50) begin
         tick();
         t++;
      end
      if (!irdy[d]) begin
         checks++;
         $display("FAIL send_timeout dut%0d got in_ready=0 want 1", d);
      end
      tick();
      iv[d] = 1'b0;
      il[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d, output bit ok);
      int t = 0;
      while (!ov[d] && t < 20) begin
         tick();
         t++;
      end
      ok = ov[d];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({ov[d], om[d], oc[d], oe[d]} !== 14'd0)
            $display("FAIL reset_outputs dut%0d got v=%b m=%h c=%0d e=%b want all 0", d, ov[d], om[d], oc[d], oe[d]);
         else passes++;
      end
      reset = 1'b0;
      tick();
      checks++;
      if (irdy !== 3'b111) $display("FAIL reset_in_ready got %b want 111", irdy);
      else passes++;
      $display("reset: outputs cleared, in_ready=%b", irdy);
   endtask

   task automatic test_basic();
      bit ok;
      tick();
      send(0, 3, 1'b0);
      send(0, 5, 1'b0);
      checks++;
      if (ov[0] !== 1'b0) $display("FAIL basic_early_valid got %b want 0", ov[0]);
      else passes++;
      send(0, 0, 1'b1);
      checks++;
      if (ov[0] !== 1'b1) $display("FAIL basic_latency got %b want 1", ov[0]);
      else passes++;
      wait_valid(0, ok);
      checks++;
      if (om[0] !== 8'b00101001) $display("FAIL basic_mask got %b want 00101001", om[0]);
      else passes++;
      checks++;
      if (oc[0] !== 4'd3 || oe[0] !== 1'b0) $display("FAIL basic_count got c=%0d e=%b want c=3 e=0", oc[0], oe[0]);
      else passes++;
      $display("basic: 3,5,0 -> mask=%b count=%0d err=%b", om[0], oc[0], oe[0]);
   endtask

   task automatic test_reverse();
      bit ok;
      tick();
      send(1, 0, 1'b1);
      wait_valid(1, ok);
      checks++;
      if (!ok || om[1] !== 8'b10000000 || oc[1] !== 4'd1)
         $display("FAIL reverse_idx0 got v=%b m=%b c=%0d want v=1 m=10000000 c=1", ok, om[1], oc[1]);
      else passes++;
      send(1, 7, 1'b1);
      wait_valid(1, ok);
      checks++;
      if (!ok || om[1] !== 8'b00000001 || oc[1] !== 4'd1)
         $display("FAIL reverse_idx7 got v=%b m=%b c=%0d want v=1 m=00000001 c=1", ok, om[1], oc[1]);
      else passes++;
      $display("reverse: idx7 -> mask=%b", om[1]);
   endtask

   task automatic test_stall();
      tick();
      ordy[0] = 1'b0;
      send(0, 2, 1'b0);
      send(0, 2, 1'b0);
      send(0, 2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (ov[0] !== 1'b1 || om[0] !== 8'b00000100 || oc[0] !== 4'd1 || irdy[0] !== 1'b0)
            $display("FAIL stall_hold cyc%0d got v=%b m=%b c=%0d rdy=%b want v=1 m=00000100 c=1 rdy=0",
                     k, ov[0], om[0], oc[0], irdy[0]);
         else passes++;
         tick();
      end
      ordy[0] = 1'b1;
      tick();
      checks++;
      if (ov[0] !== 1'b0) $display("FAIL stall_release got v=%b want 0", ov[0]);
      else passes++;
      $display("stall: held 5 cycles, released v=%b", ov[0]);
   endtask

   task automatic test_out_of_range();
      bit ok;
      tick();
      send(2, 1, 1'b0);
      send(2, 6, 1'b0);
      send(2, 7, 1'b1);
      wait_valid(2, ok);
      checks++;
      if (!ok || om[2] !== 8'b00000010 || oc[2] !== 4'd1 || oe[2] !== 1'b1)
         $display("FAIL oor_group got v=%b m=%b c=%0d e=%b want v=1 m=00000010 c=1 e=1", ok, om[2], oc[2], oe[2]);
      else passes++;
      send(2, 4, 1'b1);
      wait_valid(2, ok);
      checks++;
      if (!ok || om[2] !== 8'b00010000 || oc[2] !== 4'd1 || oe[2] !== 1'b0)
         $display("FAIL oor_next got v=%b m=%b c=%0d e=%b want v=1 m=00010000 c=1 e=0", ok, om[2], oc[2], oe[2]);
      else passes++;
      send(2, 7, 1'b1);
      wait_valid(2, ok);
      checks++;
      if (!ok || om[2] !== 8'd0 || oc[2] !== 4'd0 || oe[2] !== 1'b1)
         $display("FAIL oor_only got v=%b m=%b c=%0d e=%b want v=1 m=0 c=0 e=1", ok, om[2], oc[2], oe[2]);
      else passes++;
      $display("out_of_range: only-7 group -> mask=%b err=%b", om[2], oe[2]);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_m;
      tick();
      for (int i = 0; i < 8; i++) begin
         iv[0] = 1'b1;
         ii[0] = 3'(i);
         il[0] = 1'b1;
         checks++;
         if (irdy[0] !== 1'b1) $display("FAIL b2b_ready idx%0d got 0 want 1", i);
         else passes++;
         tick();
         exp_m = 8'd1 << i;
         checks++;
         if (ov[0] !== 1'b1 || om[0] !== exp_m || oc[0] !== 4'd1)
            $display("FAIL b2b_out idx%0d got v=%b m=%b c=%0d want v=1 m=%b c=1", i, ov[0], om[0], oc[0], exp_m);
         else passes++;
      end
      iv[0] = 1'b0;
      il[0] = 1'b0;
      $display("back_to_back: 8 single-beat groups");
   endtask

   task automatic test_reset_mid();
      bit ok;
      tick();
      send(0, 1, 1'b0);
      send(0, 4, 1'b0);
      reset = 1'b1;
      iv[0] = 1'b1;
      ii[0] = 3'd2;
      il[0] = 1'b1;
      tick();
      checks++;
      if ({ov[0], om[0], oc[0], oe[0]} !== 14'd0)
         $display("FAIL rstmid_during got v=%b m=%b c=%0d e=%b want all 0", ov[0], om[0], oc[0], oe[0]);
      else passes++;
      reset = 1'b0;
      iv[0] = 1'b0;
      il[0] = 1'b0;
      tick();
      checks++;
      if ({ov[0], om[0], oc[0], oe[0]} !== 14'd0 || irdy[0] !== 1'b1)
         $display("FAIL rstmid_after got v=%b m=%b c=%0d e=%b rdy=%b want 0s rdy=1", ov[0], om[0], oc[0], oe[0], irdy[0]);
      else passes++;
      send(0, 6, 1'b1);
      wait_valid(0, ok);
      checks++;
      if (!ok || om[0] !== 8'b01000000 || oc[0] !== 4'd1)
         $display("FAIL rstmid_group got v=%b m=%b c=%0d want v=1 m=01000000 c=1", ok, om[0], oc[0]);
      else passes++;
      $display("reset_mid: post-reset group mask=%b", om[0]);
   endtask

   task automatic test_random();
      int q[$];
      int len;
      int idx;
      int n;
      bit ok;
      logic [7:0] m;
      logic [3:0] c;
      logic e;
      for (int d = 0; d < 3; d++) begin
         n = (d == 2) ? 6 : 8;
         for (int g = 0; g < 30; g++) begin
            len = $urandom_range(1, 5);
            q.delete();
            for (int k = 0; k < len; k++) begin
               idx = $urandom_range(0, 7);
               q.push_back(idx);
               if ($urandom_range(0, 1) == 1) tick();
               send(d, idx, k == len - 1);
            end
            ref_group(n, d == 1, q, m, c, e);
            wait_valid(d, ok);
            checks++;
            if (!ok || om[d] !== m || oc[d] !== c || oe[d] !== e)
               $display("FAIL rand dut%0d grp%0d got v=%b m=%b c=%0d e=%b want v=1 m=%b c=%0d e=%b",
                        d, g, ok, om[d], oc[d], oe[d], m, c, e);
            else passes++;
            $display("rand dut%0d grp%0d len=%0d mask=%b count=%0d err=%b", d, g, len, om[d], oc[d], oe[d]);
         end
      end
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      iv    = '0;
      il    = '0;
      ii    = '0;
      ordy  = 3'b111;
      test_reset();
      test_basic();
      test_reverse();
      test_stall();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
